// File: rtl/event_encoder_83.sv
// Event encoder: latches 2**IDX_W request lines into a pending bitmap and emits one index per handshake.
// Latency: a request sampled at edge k is presented (out_valid=1) after edge k; one index per cycle under out_ready.
// Backpressure: out/out_valid hold while out_ready=0; repeat requests on a still-pending bit are merged and flag ovf.
// Optional: define ENCODER_RR_EN for round-robin priority (default is fixed lowest-index priority).
module event_encoder_83 #(
    parameter int IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  e,
    input  logic [2**IDX_W-1:0]   in,
    input  logic                  clr,
    output logic [IDX_W-1:0]      out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2**IDX_W-1:0]   pending,
    output logic                  ovf
);
    localparam int N = 2**IDX_W;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;

    logic             acc;
    logic [N-1:0]     grant;
    logic [N-1:0]     req;
    logic             load;
    logic [IDX_W-1:0] enc_idx;

`ifdef ENCODER_RR_EN
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
`endif

    // Handshake, grant mask, pending update and sticky overflow.
    always_comb begin
        acc       = (state_q == PRESENT) && out_ready;
        grant     = acc ? ({{(N-1){1'b0}}, 1'b1} << out_q) : '0;
        req       = e ? in : '0;
        pending_d = (pending_q & ~grant) | req;
        if (|(req & pending_q & ~grant)) begin
            ovf_d = 1'b1;
        end else if (clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

`ifdef ENCODER_RR_EN
    // Round-robin search of pending_d starting just after the most recently accepted index.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] start;
        logic [IDX_W-1:0] idx;
        last_idx_d = acc ? out_q : last_idx_q;
        start      = last_idx_d + 1'b1;
        enc_idx    = '0;
        found      = 1'b0;
        idx        = '0;
        for (int k = 0; k < N; k++) begin
            idx = start + k[IDX_W-1:0];
            if (!found && pending_d[idx]) begin
                enc_idx = idx;
                found   = 1'b1;
            end
        end
    end
`else
    // Fixed priority: scan from the top down so the lowest set index is the one left standing.
    always_comb begin
        enc_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_d[i]) begin
                enc_idx = i[IDX_W-1:0];
            end
        end
    end
`endif

    // Output FSM: reload when idle or when the presented index is being taken; otherwise hold.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        load    = (state_q == IDLE) || out_ready;
        if (load) begin
            if (|pending_d) begin
                state_d = PRESENT;
                out_d   = enc_idx;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef ENCODER_RR_EN
    // Remembers the last accepted index; reset to N-1 so the first search starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_idx_q <= IDX_W'(N - 1);
        end else begin
            last_idx_q <= last_idx_d;
        end
    end
`endif

    assign out       = out_q;
    assign out_valid = (state_q == PRESENT);
    assign pending   = pending_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_event_encoder_83.sv
// Bench for event_encoder_83 (default fixed-priority build): directed vectors plus a per-cycle reference model.
// Literal checks pin the test-plan scenarios; a negedge compare process checks every output against the model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge or #1 after the edge.
module tb_event_encoder_83;
    localparam int IDX_W = 3;
    localparam int N     = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             e = 1'b0;
    logic [N-1:0]     in = '0;
    logic             clr = 1'b0;
    logic [IDX_W-1:0] out;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     pending;
    logic             ovf;

    int vectors = 0;
    int miscompares = 0;

    event_encoder_83 #(.IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .e(e), .in(in), .clr(clr),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .pending(pending), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference model: pending as a bit array, presented index, valid flag, sticky overflow.
    bit m_pend [N];
    int m_out;
    bit m_valid;
    bit m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_out   = 0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            bit nxt [N];
            bit lost;
            int granted;
            int first;
            granted = (m_valid && out_ready) ? m_out : -1;
            lost = 1'b0;
            for (int i = 0; i < N; i++) begin
                bit newreq;
                newreq = e && in[i];
                if (newreq && m_pend[i] && (i != granted)) lost = 1'b1;
                nxt[i] = (m_pend[i] && (i != granted)) || newreq;
            end
            if (lost) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (!m_valid || out_ready) begin
                first = -1;
                for (int i = 0; i < N; i++)
                    if (nxt[i] && first < 0) first = i;
                if (first >= 0) begin
                    m_valid = 1'b1;
                    m_out   = first;
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) m_pend[i] = nxt[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [N-1:0] mp;
        for (int i = 0; i < N; i++) mp[i] = m_pend[i];
        check("model_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("model_out", {29'b0, out}, m_out);
        check("model_pending", {24'b0, pending}, {24'b0, mp});
        check("model_ovf", {31'b0, ovf}, {31'b0, m_ovf});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state.
        #2;
        check("rst_out", {29'b0, out}, 0);
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_pending", {24'b0, pending}, 0);
        check("rst_ovf", {31'b0, ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Single request, one-cycle latency.
        e = 1'b1; out_ready = 1'b1; in = 8'h04;
        step();
        check("t1_out", {29'b0, out}, 2);
        check("t1_valid", {31'b0, out_valid}, 1);
        check("t1_pending", {24'b0, pending}, 8'h04);
        in = 8'h00;
        step();
        check("t1_idle_valid", {31'b0, out_valid}, 0);
        check("t1_idle_pending", {24'b0, pending}, 0);

        // Two bits at once drain lowest first, back to back.
        in = 8'h81;
        step();
        check("t2_out0", {29'b0, out}, 0);
        check("t2_valid0", {31'b0, out_valid}, 1);
        in = 8'h00;
        step();
        check("t2_out7", {29'b0, out}, 7);
        check("t2_valid7", {31'b0, out_valid}, 1);
        step();
        check("t2_idle", {31'b0, out_valid}, 0);
        check("t2_ovf", {31'b0, ovf}, 0);

        // Backpressure keeps the index stable.
        out_ready = 1'b0; in = 8'h12;
        step();
        in = 8'h00;
        for (int c = 0; c < 5; c++) begin
            check("t3_hold_out", {29'b0, out}, 1);
            check("t3_hold_valid", {31'b0, out_valid}, 1);
            step();
        end
        out_ready = 1'b1;
        step();
        check("t3_next_out", {29'b0, out}, 4);
        check("t3_next_pending", {24'b0, pending}, 8'h10);
        step();
        check("t3_idle", {31'b0, out_valid}, 0);

        // Overflow on a presented-but-unaccepted bit; clr; clr vs set.
        out_ready = 1'b0; in = 8'h08;
        step();
        check("t4_out", {29'b0, out}, 3);
        step();
        check("t4_ovf_set", {31'b0, ovf}, 1);
        check("t4_pending", {24'b0, pending}, 8'h08);
        in = 8'h00; clr = 1'b1;
        step();
        check("t4_ovf_clr", {31'b0, ovf}, 0);
        in = 8'h08;
        step();
        check("t4_set_wins", {31'b0, ovf}, 1);
        in = 8'h00; clr = 1'b0; out_ready = 1'b1;
        step();
        check("t4_drained", {31'b0, out_valid}, 0);
        check("t4_ovf_sticky", {31'b0, ovf}, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Capture disabled.
        e = 1'b0; in = 8'hFF;
        repeat (3) step();
        check("t5_pending", {24'b0, pending}, 0);
        check("t5_valid", {31'b0, out_valid}, 0);
        e = 1'b1;

        // Asynchronous reset mid-stream.
        out_ready = 1'b0; in = 8'hF0;
        step();
        check("t5_pend_f0", {24'b0, pending}, 8'hF0);
        check("t5_out4", {29'b0, out}, 4);
        in = 8'h00;
        #2 rst = 1'b1;
        #1;
        check("t5_arst_out", {29'b0, out}, 0);
        check("t5_arst_valid", {31'b0, out_valid}, 0);
        check("t5_arst_pending", {24'b0, pending}, 0);
        check("t5_arst_ovf", {31'b0, ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Fixed priority starves bit 1 under a continuous 0x03 stream.
        out_ready = 1'b1; in = 8'h03;
        for (int c = 0; c < 4; c++) begin
            step();
            check("t6_out", {29'b0, out}, 0);
        end
        check("t6_ovf", {31'b0, ovf}, 1);
        in = 8'h00;
        repeat (3) step();
        check("t6_drain", {31'b0, out_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/event_encoder_83.md
Name: event_encoder_83

Overview:
- Counterpart to the team's 3-to-8 one-hot decoder: turns 8 one-hot/multi-hot event request lines back into a 3-bit index stream.
- Latches incoming request bits into a pending register, then emits one encoded index per accepted transfer over a valid/ready handshake.
- Sits between event sources (interrupt-style pulses) and a consumer that handles one event index at a time.

Parameters:
- IDX_W, 3, index width; the number of request lines N = 2**IDX_W (derived localparam, 8 by default).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- e  input  1  capture enable; when 0, in is ignored.
- in  input  N  request pulses, any number of bits set per cycle.
- clr  input  1  synchronous clear of the sticky overflow flag.
- out  output  IDX_W  encoded index of the presented event (registered).
- out_valid  output  1  out holds a pending event (registered).
- out_ready  input  1  consumer accepts out this cycle.
- pending  output  N  current pending bitmap (registered).
- ovf  output  1  sticky overflow flag (registered).

Behaviour:
- Reset (async, any time, including mid-transfer): pending=0, out=0, out_valid=0, ovf=0. Effect is immediate. Operation resumes on the first clk edge after rst deasserts.
- Accept: acc = out_valid && out_ready. The granted mask is the one-hot of out when acc=1, else 0.
- Pending update: pending_next = (pending & ~grant) | (e ? in : 0). pending <= pending_next every edge.
- A new request on the bit being granted in the same cycle keeps that bit set and counts as a new event, not an overflow.
- Output state machine has two states, held in out_valid:
  - IDLE (out_valid=0).
  - PRESENT (out_valid=1).
- Load condition: at each edge, if (!out_valid || out_ready), then out_valid <= |pending_next and out <= enc(pending_next). Otherwise out and out_valid hold.
- Index stability: out must not change while out_valid=1 and out_ready=0.
- If pending_next=0 on a load, go to IDLE and hold out at its last value.
- enc(): fixed priority, the lowest set index wins.
- Latency: a request sampled at edge k appears as out_valid=1 after edge k, i.e. one cycle.
- Throughput: one index per cycle while out_ready=1 and events remain.
- The presented bit stays set in pending until it is accepted.
- Overflow: ovf <= 1 when e && in[i] && pending[i] && !(grant[i]) for any i. The event is merged, i.e. lost.
- clr sets ovf <= 0 at the edge. If clr and a new overflow occur in the same cycle, set wins.
- e=0: in is ignored, but pending continues to drain through the handshake.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: ENCODER_RR_EN.
- Defined: round-robin priority.
  - A register last_idx (reset N-1) updates to out on every accept.
  - enc() searches pending_next starting at (last_idx+1) mod N, wrapping to 0 after N-1.
  - The first search after reset therefore starts at index 0.
- Not defined: fixed lowest-index priority, and no last_idx register exists.

Test Plan:
- Reset; e=1, in=8'b0000_0100 for one cycle, out_ready=1 -> next cycle out=2, out_valid=1, pending=8'h04; the following cycle out_valid=0, pending=0.
- in=8'b1000_0001 for one cycle, out_ready=1 held -> out=0 then out=7 on consecutive cycles, then out_valid=0, ovf=0.
- in=8'b0001_0010, out_ready=0 for 5 cycles -> out=1 stable with out_valid=1; then out_ready=1 -> out=1 accepted, out=4 next cycle, then idle.
- Backpressure with out=3 presented: pulse in[3] again -> ovf=1 and pending unchanged. Pulse clr -> ovf=0. Then clr together with another in[3] repeat -> ovf stays 1.
- e=0, in=8'hFF for 3 cycles from idle -> pending=0, out_valid=0. Assert rst mid-stream with pending=8'hF0 -> all outputs 0 immediately, without waiting for a clock.
- ENCODER_RR_EN defined: in=8'h03 every cycle, out_ready=1 -> out sequence 0,1,0,1. Undefined: same stimulus -> out stays 0 every cycle and ovf=1.
